// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - registered write-back source select with wait/timeout
// Picks one of NSRC result buses, waits for it to be valid, then issues one register-file write.
module wb_select_stage #(
  parameter int WIDTH        = 32,
  parameter int NSRC         = 10,
  parameter int SELW         = 4,
  parameter int ADDRW        = 5,
  parameter int CONST_IDX    = 5,
  parameter int CONST_VAL    = 227,
  parameter int TIMEOUT      = 64,
  parameter int ZERO_DISCARD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [SELW-1:0]       sel,
  input  logic [ADDRW-1:0]      dest,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_valid,
  output logic                  busy,
  output logic                  wr_en,
  output logic [ADDRW-1:0]      wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  done,
  output logic                  err
);

  localparam int NTAB = 1 << SELW;
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [SELW:0]     NSRC_W    = (SELW+1)'(NSRC);
  localparam logic [CNTW-1:0]   TIMEOUT_W = CNTW'(TIMEOUT);
  localparam logic [WIDTH-1:0]  CONST_W   = WIDTH'(CONST_VAL);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  // Full power-of-two table so any sel value indexes in range; unused slots read as invalid zero.
  logic [WIDTH-1:0] src_tab [NTAB];
  logic [NTAB-1:0]  valid_tab;
  logic             unused_const_src;

  for (genvar i = 0; i < NTAB; i++) begin : g_tab
    if (i == CONST_IDX) begin : g_const
      assign src_tab[i]   = CONST_W;
      assign valid_tab[i] = 1'b1;
    end else if (i < NSRC) begin : g_src
      assign src_tab[i]   = src_data[i*WIDTH +: WIDTH];
      assign valid_tab[i] = src_valid[i];
    end else begin : g_none
      assign src_tab[i]   = '0;
      assign valid_tab[i] = 1'b0;
    end
  end

  assign unused_const_src = ^{src_valid[CONST_IDX], src_data[CONST_IDX*WIDTH +: WIDTH]};

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [ADDRW-1:0] dest_q, dest_d;
  logic [CNTW-1:0]  cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + CNTW'(1);

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sel_d     = sel_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if ({1'b0, sel} >= NSRC_W) begin
            err_d = 1'b1;
          end else if (ZERO_DISCARD != 0 && dest == '0) begin
            done_d    = 1'b1;
            wr_addr_d = '0;
          end else if (valid_tab[sel]) begin
            wr_data_d = src_tab[sel];
            wr_addr_d = dest;
            sel_d     = sel;
            dest_d    = dest;
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            state_d   = S_WRITE;
          end else begin
            sel_d   = sel;
            dest_d  = dest;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Valid is checked before the counter, so a late valid beats the abort.
        if (valid_tab[sel_q]) begin
          wr_data_d = src_tab[sel_q];
          wr_addr_d = dest_q;
          wr_en_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = S_WRITE;
        end else if (cnt_inc == TIMEOUT_W) begin
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sel_q     <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sel_q     <= sel_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - self-checking bench for wb_select_stage
// Each request is predicted from its select, destination and valid-arrival delay.
module tb_wb_select_stage;

  localparam int WIDTH     = 32;
  localparam int NSRC      = 10;
  localparam int SELW      = 4;
  localparam int ADDRW     = 5;
  localparam int CONST_IDX = 5;
  localparam int CONST_VAL = 227;
  localparam int TIMEOUT   = 12;
  localparam int NEVER     = 1000;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req;
  logic [SELW-1:0]       sel;
  logic [ADDRW-1:0]      dest;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_valid;
  logic                  busy, wr_en, done, err;
  logic [ADDRW-1:0]      wr_addr;
  logic [WIDTH-1:0]      wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  wb_select_stage #(
    .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .ADDRW(ADDRW), .CONST_IDX(CONST_IDX),
    .CONST_VAL(CONST_VAL), .TIMEOUT(TIMEOUT), .ZERO_DISCARD(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .sel(sel), .dest(dest),
    .src_data(src_data), .src_valid(src_valid), .busy(busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic randomize_sources();
    for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = $urandom;
    src_valid = NSRC'($urandom);
  endtask

  // Valid for source s first seen at edge d after the request edge (d=0: already valid).
  task automatic run_txn(input logic [SELW-1:0] s, input logic [ADDRW-1:0] dst, input int d,
                         input bit noise, input bit use_force, input logic [WIDTH-1:0] force_word,
                         input string name);
    int kind;
    int wj;
    bit allowed;
    logic [WIDTH-1:0] exp_data;
    logic [3:0] exp_f, got_f;
    if (int'(s) >= NSRC)              begin kind = 0; wj = 0; end
    else if (dst == '0)               begin kind = 1; wj = 0; end
    else if (int'(s) == CONST_IDX)    begin kind = 2; wj = 0; end
    else if (d <= TIMEOUT)            begin kind = 2; wj = d; end
    else                              begin kind = 3; wj = TIMEOUT; end
    exp_data = WIDTH'(CONST_VAL);
    for (int j = 0; j <= wj + 1; j++) begin
      randomize_sources();
      if (int'(s) < NSRC) begin
        src_valid[s] = (j >= d);
        if (use_force && j == d) src_data[int'(s)*WIDTH +: WIDTH] = force_word;
      end
      if (j == 0) begin
        req = 1'b1; sel = s; dest = dst;
      end else begin
        allowed = (kind == 2 && j <= wj + 1) || (kind == 3 && j <= wj);
        req  = noise && allowed && ($urandom_range(0, 1) == 1);
        sel  = SELW'($urandom);
        dest = ADDRW'($urandom);
      end
      if (kind == 2 && j == wj && int'(s) != CONST_IDX) exp_data = src_data[int'(s)*WIDTH +: WIDTH];
      @(posedge clk);
      @(negedge clk);
      exp_f = {((kind == 2 && j <= wj) || (kind == 3 && j < wj)),
               (kind == 2 && j == wj),
               ((kind == 1 || kind == 2) && j == wj),
               ((kind == 0 || kind == 3) && j == wj)};
      got_f = {busy, wr_en, done, err};
      n_cmp++;
      if (got_f !== exp_f) begin
        n_bad++;
        $display("FAIL %s flags{busy,wr_en,done,err} j=%0d got %b want %b", name, j, got_f, exp_f);
      end
      if (exp_f[1]) begin
        n_cmp++;
        if (wr_addr !== (kind == 1 ? '0 : dst)) begin
          n_bad++;
          $display("FAIL %s wr_addr got %0d want %0d", name, wr_addr, (kind == 1 ? 0 : int'(dst)));
        end
      end
      if (exp_f[2]) begin
        n_cmp++;
        if (wr_data !== exp_data) begin
          n_bad++;
          $display("FAIL %s wr_data got %h want %h", name, wr_data, exp_data);
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; sel = '0; dest = '0; src_data = '0; src_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, wr_en, done, err, wr_addr, wr_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b wr_en=%b done=%b err=%b addr=%0d data=%h want all 0",
               busy, wr_en, done, err, wr_addr, wr_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_direct_write();
    run_txn(4'd0, 5'd8, 0, 1'b0, 1'b1, 32'h1234_5678, "direct_write");
  endtask

  task automatic test_const_source();
    run_txn(4'(CONST_IDX), 5'd3, NEVER, 1'b0, 1'b0, '0, "const_source");
  endtask

  task automatic test_wait_source();
    run_txn(4'd3, 5'd9, 10, 1'b1, 1'b1, 32'hDEAD_BEEF, "wait_hi");
  endtask

  task automatic test_timeout();
    run_txn(4'd4, 5'd7, NEVER, 1'b1, 1'b0, '0, "timeout_never");
    run_txn(4'd4, 5'd7, TIMEOUT, 1'b1, 1'b0, '0, "timeout_valid_wins");
    run_txn(4'd4, 5'd7, TIMEOUT + 1, 1'b0, 1'b0, '0, "timeout_valid_late");
  endtask

  task automatic test_bad_and_discard();
    run_txn(4'd12, 5'd4, 0, 1'b0, 1'b0, '0, "bad_sel_12");
    run_txn(4'd15, 5'd0, 0, 1'b0, 1'b0, '0, "bad_sel_15_dest0");
    run_txn(4'd2, 5'd0, 0, 1'b0, 1'b0, '0, "discard_valid");
    run_txn(4'd6, 5'd0, NEVER, 1'b0, 1'b0, '0, "discard_invalid");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++)
      run_txn(4'($urandom_range(0, NSRC - 1)), 5'($urandom_range(1, 31)), 0, 1'b1, 1'b0, '0, "back_to_back");
  endtask

  task automatic test_random();
    int r;
    int d;
    logic [ADDRW-1:0] dst;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: d = 0;
        1: d = $urandom_range(1, TIMEOUT);
        2: d = TIMEOUT + $urandom_range(0, 1);
        default: d = NEVER;
      endcase
      dst = ($urandom_range(0, 7) == 0) ? '0 : ADDRW'($urandom);
      run_txn(SELW'($urandom), dst, d, 1'b1, 1'b0, '0, "random");
    end
  endtask

  task automatic test_reset_in(input int wait_cycles, input string name);
    randomize_sources();
    req = 1'b1; sel = 4'd3; dest = 5'd9; src_valid[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < wait_cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_before_reset got %b want 1", name, busy);
    end
    reset = 1'b1; src_valid[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, wr_en, done, err, wr_addr, wr_data} !== '0) begin
      n_bad++;
      $display("FAIL %s after_reset got busy=%b wr_en=%b done=%b err=%b addr=%0d data=%h want all 0",
               name, busy, wr_en, done, err, wr_addr, wr_data);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy, wr_en, done, err} !== 4'b0) begin
        n_bad++;
        $display("FAIL %s quiet_after_reset k=%0d got %b want 0000", name, k, {busy, wr_en, done, err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_const_source();
    test_wait_source();
    test_timeout();
    test_bad_and_discard();
    test_back_to_back();
    test_random();
    test_reset_in(3, "reset_in_wait");
    test_reset_in(1, "reset_at_write_entry");
    test_direct_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised, registered write-back stage for the multicycle datapath: selects one of NSRC result sources, waits for that source to become valid (e.g. HI/LO while mult/div is running), then issues a single-cycle register-file write. It sits between the datapath result buses and the register bank write port, driven by the control unit's write-back request.

## Interface

Parameters:

- WIDTH, 32, data width of every source and of wr_data
- NSRC, 10, number of selectable sources
- SELW, 4, select width; must satisfy 2^SELW >= NSRC
- ADDRW, 5, register address width
- CONST_IDX, 5, source index replaced by an internal constant
- CONST_VAL, 227, constant value returned at CONST_IDX, zero-extended to WIDTH
- TIMEOUT, 64, maximum WAIT cycles before abort; must be >= 1
- ZERO_DISCARD, 1, if 1, a write to address 0 completes without asserting wr_en

Ports:

- clk  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  write-back request, sampled only in IDLE
- sel  in  SELW  source index, sampled with req
- dest  in  ADDRW  destination register, sampled with req
- src_data  in  NSRC*WIDTH  flattened sources; source i is bits [i*WIDTH +: WIDTH]
- src_valid  in  NSRC  per-source valid; bit CONST_IDX is ignored (constant is always valid)
- busy  out  1  high whenever state is not IDLE
- wr_en  out  1  register-file write strobe, one cycle
- wr_addr  out  ADDRW  write address, valid while wr_en or done
- wr_data  out  WIDTH  write data, valid while wr_en
- done  out  1  one-cycle pulse: request completed (written or discarded)
- err  out  1  one-cycle pulse: request aborted (bad select or timeout)

## Operation

- States: IDLE, WAIT, WRITE. Reset forces IDLE. All outputs are registered and reset to 0: busy, wr_en, wr_addr, wr_data, done, err, and the internal sel/dest/counter latches.
- IDLE with req=1, evaluated in priority order:
  - sel >= NSRC: err=1 next cycle, stay IDLE, no write.
  - dest==0 and ZERO_DISCARD=1: done=1 next cycle with wr_en=0 and wr_addr=0, stay IDLE.
  - source valid: capture data and dest, go to WRITE.
  - otherwise: latch sel and dest, clear the counter, go to WAIT.
- IDLE with req=0: no state change and no outputs.
- WAIT: each cycle, check src_valid[latched sel].
  - Valid: capture data, go to WRITE.
  - Invalid: increment the counter. When the counter reaches TIMEOUT, go to IDLE with err=1 and no write.
  - If valid rises in the same cycle the counter would reach TIMEOUT, valid wins.
- WRITE: wr_en=1 and done=1 for exactly one cycle with the captured wr_addr and wr_data, then IDLE.
- Data is captured at the transition into WRITE. Later changes to src_data do not affect wr_data.
- req while busy=1 is ignored and not queued.
- reset asserted in any state: next cycle is IDLE with all outputs 0. An in-flight write is dropped, and wr_en is never asserted in the cycle after reset.

## Timing

- Valid source: req at edge t gives wr_en and done at t+1, busy at t+1, busy low at t+2. The next req is accepted at edge t+2, so the sustained rate is one write per 2 cycles.
- Waiting source: src_valid first seen high at edge w gives wr_en at w+1.
- Timeout: WAIT entered at t+1 with no valid gives err at t+1+TIMEOUT (state IDLE, busy low).
- Bad select and discarded writes give err or done at t+1 with busy staying 0.
- err and done are never high together. wr_en implies done.

## Test plan

- Reset, then req with sel=0, dest=8 and source 0 = 0x1234_5678, valid -> one cycle later: wr_en=1, wr_addr=8, wr_data=0x12345678, done=1; all low the cycle after.
- req with sel=5, dest=3 and src_valid=0 -> next cycle wr_en=1, wr_data=227 (0x000000E3), no WAIT entered.
- req with sel=3 (HI), dest=9, src_valid[3]=0; raise valid after 10 cycles with data 0xDEADBEEF -> busy for 11 cycles, wr_en one cycle after valid rises, wr_data=0xDEADBEEF. A second req issued during WAIT is ignored.
- TIMEOUT=4, req with sel=4 and valid never rising -> err pulse 5 cycles after req, no wr_en. With valid rising on the 4th WAIT cycle -> write occurs and no err.
- req with sel=12 -> err next cycle, busy stays 0. req with dest=0 and a valid source -> done=1 with wr_en=0.
- reset pulsed in WAIT, and separately in the WRITE-entry cycle -> IDLE next cycle, all outputs 0, no write observed.
